// File: rtl/fig_04b_regsel_ctrl_pkg.sv
// rtl/fig_04b_regsel_ctrl_pkg.sv - shared constants and types for the GSU register-select sequencer
package fig_04b_regsel_ctrl_pkg;

  localparam int         NREG_DEFAULT = 16;
  localparam int         SELW         = 4;
  localparam int         PC_REG_IDX   = 15;

  localparam logic [7:0] OP_ALT1      = 8'h3D;
  localparam logic [7:0] OP_ALT2      = 8'h3E;
  localparam logic [7:0] OP_ALT3      = 8'h3F;
  localparam logic [3:0] OP_TO_HI     = 4'h1;
  localparam logic [3:0] OP_WITH_HI   = 4'h2;
  localparam logic [3:0] OP_FROM_HI   = 4'hB;
  localparam logic [7:0] OP_BR_LO     = 8'h05;
  localparam logic [7:0] OP_BR_HI     = 8'h0F;

  typedef enum logic [1:0] {
    WR_SRC_ALU  = 2'd0,
    WR_SRC_LOAD = 2'd1,
    WR_SRC_HOST = 2'd2,
    WR_SRC_MOVE = 2'd3
  } wr_src_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic [SELW-1:0] sel;
    wr_src_e         src;
  } wr_req_t;

  function automatic logic is_branch(input logic [7:0] op);
    return (op >= OP_BR_LO) && (op <= OP_BR_HI);
  endfunction

endpackage

// File: rtl/fig_04b_regsel_wrarb.sv
// rtl/fig_04b_regsel_wrarb.sv - register-file write-port arbiter with one-entry hold buffer
module fig_04b_regsel_wrarb
  import fig_04b_regsel_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset_l,
  input  logic            go,
  input  logic            ld_we,
  input  logic [SELW-1:0] ld_dst,
  input  logic            host_we,
  input  logic [SELW-1:0] ha,
  input  logic            core_vld,
  input  wr_req_t         core_req,
  output logic            run_ok,
  output logic            host_ack,
  output logic            wr_en,
  output logic [SELW-1:0] wr_sel,
  output logic [1:0]      wr_src
);

  state_e  state_q, state_d;
  wr_req_t buf_q, buf_d;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= ST_IDLE;
      buf_q   <= '{sel: '0, src: WR_SRC_ALU};
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    wr_en    = 1'b0;
    wr_sel   = '0;
    wr_src   = WR_SRC_ALU;
    host_ack = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A load still in flight when go dropped outranks the host.
        if (ld_we) begin
          wr_en  = 1'b1;
          wr_sel = ld_dst;
          wr_src = WR_SRC_LOAD;
        end else if (host_we) begin
          wr_en    = 1'b1;
          wr_sel   = ha;
          wr_src   = WR_SRC_HOST;
          host_ack = 1'b1;
        end
        if (go) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!go) state_d = ST_IDLE;
        if (ld_we) begin
          wr_en  = 1'b1;
          wr_sel = ld_dst;
          wr_src = WR_SRC_LOAD;
          if (core_vld) begin
            buf_d   = core_req;
            state_d = ST_HOLD;
          end
        end else if (core_vld) begin
          wr_en  = 1'b1;
          wr_sel = core_req.sel;
          wr_src = core_req.src;
        end
      end
      ST_HOLD: begin
        // A load arriving here still wins; the buffered entry waits another cycle.
        if (ld_we) begin
          wr_en  = 1'b1;
          wr_sel = ld_dst;
          wr_src = WR_SRC_LOAD;
        end else begin
          wr_en   = 1'b1;
          wr_sel  = buf_q.sel;
          wr_src  = buf_q.src;
          state_d = go ? ST_RUN : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign run_ok = (state_q == ST_RUN);

endmodule

// File: rtl/fig_04b_regsel_ctrl.sv
// rtl/fig_04b_regsel_ctrl.sv - GSU prefix tracker and register-select sequencer
// FIG04B_ALT3_EN: when defined, opcode 0x3F acts as a combined ALT1+ALT2 prefix.
module fig_04b_regsel_ctrl
  import fig_04b_regsel_ctrl_pkg::*;
#(
  parameter int NREG   = NREG_DEFAULT,
  parameter int PC_REG = PC_REG_IDX
) (
  input  logic            clk,
  input  logic            reset_l,
  input  logic            go,
  input  logic            op_valid,
  input  logic [7:0]      op,
  output logic            op_ready,
  input  logic            resflags,
  input  logic            exec_we,
  input  logic            ld_we,
  input  logic [SELW-1:0] ld_dst,
  input  logic            host_we,
  input  logic [SELW-1:0] ha,
  output logic            host_ack,
  output logic [SELW-1:0] sreg,
  output logic [SELW-1:0] dreg,
  output logic            bflag,
  output logic            alt1,
  output logic            alt2,
  output logic [SELW-1:0] ysel,
  output logic [SELW-1:0] zsel,
  output logic            wr_en,
  output logic [SELW-1:0] wr_sel,
  output logic [1:0]      wr_src,
  output logic            moves_flags,
  output logic            pc_wr
);

  logic [SELW-1:0] sreg_q, sreg_d, dreg_q, dreg_d;
  logic            bflag_q, bflag_d, alt1_q, alt1_d, alt2_q, alt2_d;

  logic            run_ok, accept;
  logic [3:0]      op_hi, op_n;
  logic            is_to, is_with, is_from;
  logic            move_op, moves_op, core_vld;
  wr_req_t         core_req;

  assign op_hi    = op[7:4];
  assign op_n     = op[3:0];
  assign is_to    = (op_hi == OP_TO_HI);
  assign is_with  = (op_hi == OP_WITH_HI);
  assign is_from  = (op_hi == OP_FROM_HI);

  assign op_ready = run_ok;
  assign accept   = op_valid && run_ok;
  assign move_op  = accept && bflag_q && is_to;
  assign moves_op = accept && bflag_q && is_from;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      sreg_q  <= '0;
      dreg_q  <= '0;
      bflag_q <= 1'b0;
      alt1_q  <= 1'b0;
      alt2_q  <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      dreg_q  <= dreg_d;
      bflag_q <= bflag_d;
      alt1_q  <= alt1_d;
      alt2_q  <= alt2_d;
    end
  end

  always_comb begin
    sreg_d  = sreg_q;
    dreg_d  = dreg_q;
    bflag_d = bflag_q;
    alt1_d  = alt1_q;
    alt2_d  = alt2_q;
    if (resflags) begin
      sreg_d  = '0;
      dreg_d  = '0;
      bflag_d = 1'b0;
      alt1_d  = 1'b0;
      alt2_d  = 1'b0;
    end else if (accept) begin
      if (op == OP_ALT1) begin
        alt1_d = 1'b1;
      end else if (op == OP_ALT2) begin
        alt2_d = 1'b1;
`ifdef FIG04B_ALT3_EN
      end else if (op == OP_ALT3) begin
        alt1_d = 1'b1;
        alt2_d = 1'b1;
`endif
      end else if (is_with) begin
        sreg_d  = op_n;
        dreg_d  = op_n;
        bflag_d = 1'b1;
      end else if (is_to && !bflag_q) begin
        dreg_d = op_n;
      end else if (is_from && !bflag_q) begin
        sreg_d = op_n;
      end else if (!is_branch(op)) begin
        // MOVE, MOVES and every executing opcode end the prefix chain.
        sreg_d  = '0;
        dreg_d  = '0;
        bflag_d = 1'b0;
        alt1_d  = 1'b0;
        alt2_d  = 1'b0;
      end
    end
  end

  always_comb begin
    core_req = '{sel: dreg_q, src: WR_SRC_ALU};
    core_vld = 1'b0;
    if (move_op) begin
      core_req = '{sel: op_n, src: WR_SRC_MOVE};
      core_vld = 1'b1;
    end else if (moves_op) begin
      core_req = '{sel: dreg_q, src: WR_SRC_MOVE};
      core_vld = 1'b1;
    end else if (accept && exec_we) begin
      core_vld = 1'b1;
    end
  end

  fig_04b_regsel_wrarb u_wrarb (
    .clk      (clk),
    .reset_l  (reset_l),
    .go       (go),
    .ld_we    (ld_we),
    .ld_dst   (ld_dst),
    .host_we  (host_we),
    .ha       (ha),
    .core_vld (core_vld),
    .core_req (core_req),
    .run_ok   (run_ok),
    .host_ack (host_ack),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_src   (wr_src)
  );

  assign ysel        = (op_valid && bflag_q && is_from) ? op_n : sreg_q;
  assign zsel        = op_n;
  assign moves_flags = moves_op;
  assign pc_wr       = wr_en && (PC_REG < NREG) && (int'(wr_sel) == PC_REG);

  assign sreg  = sreg_q;
  assign dreg  = dreg_q;
  assign bflag = bflag_q;
  assign alt1  = alt1_q;
  assign alt2  = alt2_q;

endmodule

// File: tb/tb_fig_04b_regsel_ctrl.sv
// tb/tb_fig_04b_regsel_ctrl.sv - directed self-checking bench for fig_04b_regsel_ctrl
module tb_fig_04b_regsel_ctrl;

  logic       clk, reset_l, go, op_valid, op_ready, resflags, exec_we, ld_we, host_we, host_ack;
  logic [7:0] op;
  logic [3:0] ld_dst, ha, sreg, dreg, ysel, zsel, wr_sel;
  logic       bflag, alt1, alt2, wr_en, moves_flags, pc_wr;
  logic [1:0] wr_src;
  int         errors = 0;
  int         checks = 0;
  logic       exp_alt3;

  fig_04b_regsel_ctrl dut (
    .clk(clk), .reset_l(reset_l), .go(go), .op_valid(op_valid), .op(op), .op_ready(op_ready),
    .resflags(resflags), .exec_we(exec_we), .ld_we(ld_we), .ld_dst(ld_dst), .host_we(host_we),
    .ha(ha), .host_ack(host_ack), .sreg(sreg), .dreg(dreg), .bflag(bflag), .alt1(alt1),
    .alt2(alt2), .ysel(ysel), .zsel(zsel), .wr_en(wr_en), .wr_sel(wr_sel), .wr_src(wr_src),
    .moves_flags(moves_flags), .pc_wr(pc_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_prefix(input string tag, input logic [3:0] s, input logic [3:0] d,
                            input logic b, input logic a1, input logic a2);
    chk({tag, ".sreg"}, sreg, s);
    chk({tag, ".dreg"}, dreg, d);
    chk({tag, ".bflag"}, bflag, b);
    chk({tag, ".alt1"}, alt1, a1);
    chk({tag, ".alt2"}, alt2, a2);
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [3:0] sel, input logic [1:0] src);
    chk({tag, ".wr_en"}, wr_en, en);
    if (en) begin
      chk({tag, ".wr_sel"}, wr_sel, sel);
      chk({tag, ".wr_src"}, wr_src, src);
    end
  endtask

  initial begin
`ifdef FIG04B_ALT3_EN
    exp_alt3 = 1'b1;
`else
    exp_alt3 = 1'b0;
`endif
    reset_l = 1'b0; go = 1'b1; op_valid = 1'b0; op = 8'h00; resflags = 1'b0;
    exec_we = 1'b0; ld_we = 1'b0; ld_dst = 4'h0; host_we = 1'b0; ha = 4'h0;
    tick(); tick();
    go = 1'b0;
    #1;
    chk_prefix("reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("reset.wr_en", wr_en, 1'b0);
    chk("reset.host_ack", host_ack, 1'b0);
    chk("reset.op_ready", op_ready, 1'b0);
    chk("reset.moves_flags", moves_flags, 1'b0);
    chk("reset.pc_wr", pc_wr, 1'b0);
    reset_l = 1'b1;
    tick();

    // Host write to R15 while idle
    host_we = 1'b1; ha = 4'hF;
    #1;
    chk_wr("host", 1'b1, 4'hF, 2'd2);
    chk("host.ack", host_ack, 1'b1);
    chk("host.pc_wr", pc_wr, 1'b1);
    chk("host.op_ready", op_ready, 1'b0);
    host_we = 1'b0;
    go = 1'b1;
    tick();
    chk("run.op_ready", op_ready, 1'b1);
    host_we = 1'b1; ha = 4'h3;
    #1;
    chk("run.host_ack", host_ack, 1'b0);
    chk("run.host_wr_en", wr_en, 1'b0);
    host_we = 1'b0;

    // WITH R3 then MOVE R5 <- R3
    op_valid = 1'b1; op = 8'h23;
    tick();
    chk_prefix("with", 4'h3, 4'h3, 1'b1, 1'b0, 1'b0);
    op = 8'h15;
    #1;
    chk_wr("move", 1'b1, 4'h5, 2'd3);
    chk("move.ysel", ysel, 4'h3);
    chk("move.pc_wr", pc_wr, 1'b0);
    chk("move.moves_flags", moves_flags, 1'b0);
    tick();
    chk_prefix("move_after", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // ALT1, TO R7, branch, FROM R2, executing op 0x50
    op = 8'h3D; tick();
    chk("chain.alt1", alt1, 1'b1);
    op = 8'h17; tick();
    chk_prefix("chain_to", 4'h0, 4'h7, 1'b0, 1'b1, 1'b0);
    op = 8'h05; tick();
    chk_prefix("chain_branch", 4'h0, 4'h7, 1'b0, 1'b1, 1'b0);
    op = 8'hB2; tick();
    chk_prefix("chain_from", 4'h2, 4'h7, 1'b0, 1'b1, 1'b0);
    op = 8'h50; exec_we = 1'b1;
    #1;
    chk("exec.ysel", ysel, 4'h2);
    chk("exec.zsel", zsel, 4'h0);
    chk_wr("exec", 1'b1, 4'h7, 2'd0);
    chk_prefix("exec_during", 4'h2, 4'h7, 1'b0, 1'b1, 1'b0);
    tick();
    exec_we = 1'b0;
    chk_prefix("exec_after", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // WITH R15 then MOVES R15 <- R6
    op = 8'h2F; tick();
    op = 8'hB6;
    #1;
    chk_wr("moves", 1'b1, 4'hF, 2'd3);
    chk("moves.ysel", ysel, 4'h6);
    chk("moves.flags", moves_flags, 1'b1);
    chk("moves.pc_wr", pc_wr, 1'b1);
    tick();
    chk_prefix("moves_after", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("moves_after.flags", moves_flags, 1'b0);

    // Load collides with exec: load first, buffered exec next
    op = 8'h14; tick();
    chk("coll.dreg", dreg, 4'h4);
    op = 8'h50; exec_we = 1'b1; ld_we = 1'b1; ld_dst = 4'h9;
    #1;
    chk_wr("coll0", 1'b1, 4'h9, 2'd1);
    tick();
    op_valid = 1'b0; exec_we = 1'b0; ld_we = 1'b0;
    #1;
    chk("coll1.op_ready", op_ready, 1'b0);
    chk_wr("coll1", 1'b1, 4'h4, 2'd0);
    tick();
    chk("coll2.op_ready", op_ready, 1'b1);
    chk("coll2.wr_en", wr_en, 1'b0);

    // Load during HOLD still wins; buffered entry survives
    op_valid = 1'b1; op = 8'h14; tick();
    op = 8'h50; exec_we = 1'b1; ld_we = 1'b1; ld_dst = 4'h9;
    tick();
    op_valid = 1'b0; exec_we = 1'b0; ld_dst = 4'h2;
    #1;
    chk_wr("hold_ld", 1'b1, 4'h2, 2'd1);
    chk("hold_ld.op_ready", op_ready, 1'b0);
    tick();
    ld_we = 1'b0;
    #1;
    chk_wr("hold_drain", 1'b1, 4'h4, 2'd0);
    tick();
    chk("hold_done.op_ready", op_ready, 1'b1);

    // ALT2, then 0x3F, then executing 0x60
    op_valid = 1'b1; op = 8'h3E; tick();
    chk("alt2", alt2, 1'b1);
    op = 8'h3F; tick();
    op = 8'h60;
    #1;
    chk("alt3.alt1", alt1, exp_alt3);
    chk("alt3.alt2", alt2, exp_alt3);
    tick();
    chk_prefix("alt3_after", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // resflags beats a simultaneous WITH
    op = 8'h3D; tick();
    op = 8'h2A; resflags = 1'b1; tick();
    resflags = 1'b0;
    chk_prefix("resflags", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Prefix state survives go toggling; host owns the port in IDLE
    op = 8'h17; tick();
    op_valid = 1'b0; go = 1'b0; tick();
    chk("idle.op_ready", op_ready, 1'b0);
    chk("idle.dreg", dreg, 4'h7);
    host_we = 1'b1; ha = 4'h2;
    #1;
    chk_wr("idle_host", 1'b1, 4'h2, 2'd2);
    chk("idle_host.ack", host_ack, 1'b1);
    chk("idle_host.pc_wr", pc_wr, 1'b0);
    host_we = 1'b0; go = 1'b1; tick();
    chk("rerun.dreg", dreg, 4'h7);
    chk("rerun.op_ready", op_ready, 1'b1);

    // Reset during HOLD discards the buffered write
    op_valid = 1'b1; op = 8'h50; exec_we = 1'b1; ld_we = 1'b1; ld_dst = 4'h9;
    tick();
    op_valid = 1'b0; exec_we = 1'b0; ld_we = 1'b0;
    reset_l = 1'b0;
    #1;
    chk("rst_hold.wr_en", wr_en, 1'b0);
    chk("rst_hold.op_ready", op_ready, 1'b0);
    reset_l = 1'b1;
    tick();
    chk("rst_idle.wr_en", wr_en, 1'b0);
    tick();
    chk("rst_run.wr_en", wr_en, 1'b0);
    chk("rst_run.op_ready", op_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fig_04b_regsel_ctrl.md
Name: fig_04b_regsel_ctrl

Overview:
Sequencer for the GSU register-file select path.
- Tracks prefix state (ALT1/ALT2, FROM/TO/WITH, B flag) across the opcode stream.
- Drives Sreg/Dreg and the ysel/zsel read-port selects consumed by the select block.
- Arbitrates the single register-file write port between host, delayed RAM/ROM load, MOVE and ALU/exec results.
- Sits between opcode fetch/decode and the register file/ALU, with the R15 write flag going to the fetch unit.

Parameters:
NREG, 16, number of general registers (select width fixed at 4 bits)
PC_REG, 15, register index whose write redirects fetch

Ports:
clk  in  1  system clock
reset_l  in  1  reset
go  in  1  GSU running; 0 = host owns the register file
op_valid  in  1  opcode present
op  in  8  opcode byte
op_ready  out  1  opcode accepted this cycle
resflags  in  1  synchronous clear of all prefix state
exec_we  in  1  ALU result ready for dreg (same cycle as op accept)
ld_we  in  1  delayed load completing
ld_dst  in  4  load destination register
host_we  in  1  host register write request
ha  in  4  host register address
host_ack  out  1  host write performed
sreg  out  4  current source register
dreg  out  4  current destination register
bflag  out  1  WITH-prefix flag
alt1  out  1  ALT1 mode
alt2  out  1  ALT2 mode
ysel  out  4  read-port Y select
zsel  out  4  read-port Z select
wr_en  out  1  register-file write strobe
wr_sel  out  4  register written
wr_src  out  2  0 ALU, 1 load, 2 host, 3 move
moves_flags  out  1  one-cycle pulse: MOVES flag update for the ALU
pc_wr  out  1  wr_en with wr_sel==PC_REG

Behaviour:
- Reset: interface is clk and reset_l; reset is asynchronous and active-low.
  - On reset: sreg, dreg, bflag, alt1, alt2 = 0; state IDLE.
  - On reset: wr_en, host_ack, op_ready, moves_flags, pc_wr = 0; hold buffer empty.
- States:
  - IDLE (go=0): host_we -> wr_en=1, wr_sel=ha, wr_src=2, host_ack same cycle; op_ready=0.
  - RUN (go=1): op_ready=1 unless the hold buffer is full; host_ack=0, host writes stall.
  - HOLD: drains the buffered exec write (wr_src=0, wr_sel=buffered dreg); op_ready=0; returns to RUN next cycle.
  - go falling: finish any HOLD drain, then enter IDLE.
  - Prefix state survives go toggling; only reset_l or resflags clear it.
- Opcode effects on accept (op_valid & op_ready), registered, visible next cycle:
  - 0x3D: alt1=1.
  - 0x3E: alt2=1.
  - 0x2n WITH: sreg=dreg=n, bflag=1.
  - 0x1n, bflag=0 (TO): dreg=n.
  - 0x1n, bflag=1 (MOVE): write Rn from sreg (ysel=sreg, wr_src=3), then clear prefix state.
  - 0xBn, bflag=0 (FROM): sreg=n.
  - 0xBn, bflag=1 (MOVES): write dreg from Rn (ysel=n, wr_src=3), moves_flags=1, then clear prefix state.
  - 0x05–0x0F branches: prefix state preserved.
  - Any other opcode: executes with current state, then sreg=dreg=0, bflag=alt1=alt2=0.
- Read selects (combinational): ysel=sreg except MOVE/MOVES as above; zsel=op[3:0].
- Write priority in RUN: ld_we > MOVE > exec_we.
  - ld_we collides with exec_we or MOVE: load writes; the loser is latched (sel, src) in a one-entry hold buffer; next cycle is HOLD.
  - A second collision while HOLD is impossible because op_ready=0 in HOLD.
  - If it occurs anyway, the load still wins and the buffer keeps its entry (assertion in bench).
- resflags with a simultaneous prefix opcode: resflags wins; result is all-clear.
- pc_wr=wr_en&&(wr_sel==PC_REG) in every state, including host writes.
- Reset asserted mid-HOLD discards the buffered write.

Optional Feature:
FIG04B_ALT3_EN:
- Defined: 0x3F sets alt1=alt2=1 as a prefix.
- Undefined: 0x3F is a plain NOP and clears prefix state like any non-prefix opcode.

Decomposition:
- Shared package: opcode constants (OP_ALT1/2/3, OP_TO/WITH/FROM high nibbles, branch range), wr_src encodings, state encodings, PC_REG.
- Natural sub-module: fig_04b_regsel_wrarb (priority mux + hold buffer + HOLD state).
- Prefix tracking stays in the top module.

Test Plan:
- Reset low mid-run, then high -> all outputs 0; state IDLE with go=0.
- go=0, host_we=1, ha=4'hF -> wr_en=1, wr_sel=15, wr_src=2, host_ack=1, pc_wr=1.
- go=1: ops 0x23, 0x15 -> after 0x23: sreg=dreg=3, bflag=1; 0x15: wr_en, wr_sel=5, ysel=3, wr_src=3; next cycle all prefix state 0.
- Ops 0x3D, 0x17, 0xB2, 0x50 -> alt1=1, dreg=7, sreg=2 held through 0x50; cleared the following cycle; a branch 0x05 in the chain leaves state unchanged.
- exec_we with ld_we (ld_dst=9, dreg=4) -> cycle 0: wr_sel=9, src=1, op_ready=0 next; cycle 1: wr_sel=4, src=0; then RUN.
- With and without FIG04B_ALT3_EN: 0x3F then 0x60 -> alt1=alt2=1 during 0x60 (defined) vs both 0 (undefined); resflags with 0x2A -> all zero.
